// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and sizing helpers for the data memory controller
//
// Purpose: state encoding for the controller FSM plus constant functions that
// derive byte-lane count, byte-offset bits and word-index width from the
// module parameters.
// Ports: none (package).

package dmem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((longint'(1) << r) < longint'(value)) r++;
    return r;
  endfunction

  function automatic int lanes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int off_bits_of(input int data_width);
    return clog2(data_width / 8);
  endfunction

  // Word-index width, never narrower than one bit so DEPTH=1 still elaborates.
  function automatic int idx_bits_of(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LANES      = DEF_DATA_WIDTH / 8;
  localparam int DEF_OFF_BITS   = clog2(DEF_LANES);

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bundle between the MEM stage and the data memory controller
//
// Purpose: groups the valid/ready request channel, the response pulse and the
// init_done status.
// Modports:
//   master - pipeline side: drives req_*, observes req_ready, resp_*, init_done
//   slave  - controller side: the reverse

interface dmem_if
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                            req_valid;
  logic                            req_ready;
  logic                            req_we;
  logic [ADDR_WIDTH-1:0]           req_addr;
  logic [DATA_WIDTH-1:0]           req_wdata;
  logic [lanes_of(DATA_WIDTH)-1:0] req_wstrb;
  logic                            resp_valid;
  logic [DATA_WIDTH-1:0]           resp_rdata;
  logic                            resp_err;
  logic                            init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err, init_done
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-organised RAM with per-byte write enables and registered read
//
// Purpose: plain storage; no reset, contents are cleared by the controller's sweep.
// Ports:
//   clock - rising-edge clock
//   addr  - word index shared by read and write
//   we    - write enable, qualified per lane by be
//   be    - byte-lane enables
//   wdata - write data
//   re    - read enable; rdata updates only when set
//   rdata - registered read data (one cycle after re)

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                              clock,
  input  logic [idx_bits_of(DEPTH)-1:0]     addr,
  input  logic                              we,
  input  logic [lanes_of(DATA_WIDTH)-1:0]   be,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic                              re,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int LANES = lanes_of(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - data memory controller: zero-fill sweep, address checks, pipelined responses
//
// Purpose: accepts one request per cycle after a DEPTH-cycle zero-fill sweep,
// rejects misaligned or out-of-range addresses, and returns a response LAT
// cycles (1 or 2) after acceptance.
// Ports:
//   clock     - rising-edge clock
//   reset_n   - asynchronous active-low reset
//   bus       - dmem_if.slave: req_valid/req_ready/req_we/req_addr/req_wdata/
//               req_wstrb in, resp_valid/resp_rdata/resp_err/init_done out
//   rd_count, wr_count, err_count - 32-bit access counters, present only
//               when DMEM_STATS_EN is defined

module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int LAT        = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  dmem_if.slave       bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
`endif
);

  localparam int LANES    = lanes_of(DATA_WIDTH);
  localparam int OFF_BITS = off_bits_of(DATA_WIDTH);
  localparam int IDX_W    = idx_bits_of(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_WORD = IDX_W'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  p1_valid_q, p1_valid_d;
  logic                  p1_err_q, p1_err_d;
  logic                  p1_rd_q, p1_rd_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  misaligned, out_of_range, addr_bad;
  logic                  accept, acc_err, acc_wr, acc_rd;

  logic [IDX_W-1:0]      arr_addr;
  logic                  arr_we, arr_re;
  logic [LANES-1:0]      arr_be;
  logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;

  logic                  fin_valid, fin_err;
  logic [DATA_WIDTH-1:0] fin_data, s1_data;

  // Address decode and request classification.
  always_comb begin
    word_idx     = bus.req_addr >> OFF_BITS;
    misaligned   = |(bus.req_addr & OFF_MASK);
    out_of_range = (word_idx >= DEPTH_A);
    addr_bad     = misaligned || out_of_range;
    accept       = bus.req_valid && (state_q == IDLE);
    acc_err      = accept && addr_bad;
    acc_wr       = accept && !addr_bad && bus.req_we;
    acc_rd       = accept && !addr_bad && !bus.req_we;
  end

  // The sweep owns the array port during INIT; no request is accepted then.
  always_comb begin
    if (state_q == INIT) begin
      arr_addr  = cnt_q;
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_wdata = '0;
    end else begin
      arr_addr  = word_idx[IDX_W-1:0];
      arr_we    = acc_wr;
      arr_be    = bus.req_wstrb;
      arr_wdata = bus.req_wdata;
    end
    arr_re = acc_rd;
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clock (clock),
    .addr  (arr_addr),
    .we    (arr_we),
    .be    (arr_be),
    .wdata (arr_wdata),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

  // FSM next state: sweep one word per cycle, then stay in IDLE until reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_WORD) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // First response stage; read data itself lives in the array's output register.
  always_comb begin
    p1_valid_d = accept;
    p1_err_d   = acc_err;
    p1_rd_d    = acc_rd;
  end

  assign s1_data = p1_rd_q ? arr_rdata : '0;

  if (LAT >= 2) begin : g_lat2
    logic                  p2_valid_q, p2_valid_d;
    logic                  p2_err_q, p2_err_d;
    logic [DATA_WIDTH-1:0] p2_data_q, p2_data_d;

    always_comb begin
      p2_valid_d = p1_valid_q;
      p2_err_d   = p1_err_q;
      p2_data_d  = s1_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        p2_valid_q <= 1'b0;
        p2_err_q   <= 1'b0;
        p2_data_q  <= '0;
      end else begin
        p2_valid_q <= p2_valid_d;
        p2_err_q   <= p2_err_d;
        p2_data_q  <= p2_data_d;
      end
    end

    assign fin_valid = p2_valid_q;
    assign fin_err   = p2_err_q;
    assign fin_data  = p2_data_q;
  end else begin : g_lat1
    assign fin_valid = p1_valid_q;
    assign fin_err   = p1_err_q;
    assign fin_data  = s1_data;
  end

  // resp_rdata shows the last response's data between pulses; resp_err does not hold.
  always_comb begin
    hold_d = fin_valid ? fin_data : hold_q;
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = fin_valid;
  assign bus.resp_err   = fin_valid && fin_err;
  assign bus.resp_rdata = fin_valid ? fin_data : hold_q;
  assign bus.init_done  = init_done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_err_q    <= 1'b0;
      p1_rd_q     <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      p1_valid_q  <= p1_valid_d;
      p1_err_q    <= p1_err_d;
      p1_rd_q     <= p1_rd_d;
      hold_q      <= hold_d;
    end
  end

`ifdef DMEM_STATS_EN
  // An errored request counts only as an error; sweep writes never count.
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic [31:0] err_count_q, err_count_d;

  always_comb begin
    rd_count_d  = rd_count_q  + (acc_rd  ? 32'd1 : 32'd0);
    wr_count_d  = wr_count_q  + (acc_wr  ? 32'd1 : 32'd0);
    err_count_d = err_count_q + (acc_err ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;
`endif

endmodule
